// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed by a small write FIFO.
// Bit timing is counted in OVERSAMPLE baud_en ticks per bit; queued bytes go out back-to-back.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_n;
  logic                 push_c, pop_c;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [TICK_W-1:0]    tick, tick_n;
  logic                 tx_n, busy_n, bit_end_c;

  // Writes into a full FIFO are dropped, judged on the pre-edge full flag.
  assign push_c  = wr_en && !full;
  assign count_n = count + CNT_W'(push_c) - CNT_W'(pop_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_n;
      full  <= (count_n == CNT_W'(FIFO_DEPTH));
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

  // A bit period closes on the edge that samples its last baud tick.
  assign bit_end_c = baud_en && (tick == TICK_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tick    <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      tick    <= tick_n;
      tx      <= tx_n;
      tx_busy <= busy_n;
    end
  end

  // tx_done is high during the clk whose edge closes the stop bit.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    tick_n    = tick;
    tx_n      = tx;
    busy_n    = tx_busy;
    pop_c     = 1'b0;
    tx_done   = 1'b0;

    if (baud_en && (state != IDLE)) begin
      tick_n = bit_end_c ? '0 : tick + TICK_W'(1);
    end

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (!empty) begin
          pop_c   = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
          tick_n  = '0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end_c) begin
          state_n   = DATA;
          tx_n      = shift[0];
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n   = shift >> 1;
            tx_n      = shift[1];
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          tx_done = 1'b1;
          if (!empty) begin
            pop_c   = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: expected bytes go into a scoreboard queue when written,
// a pulse-counting receiver model decodes tx and pops/compares each frame.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, tx, tx_busy, tx_done;

  int total = 0;
  int bad   = 0;
  int baud_mode = 0;  // 0 off, 1 every clk, 2 every 4 clks, 3 random
  int baud_div  = 0;

  logic [7:0] exp_q[$];
  int   n_done   = 0;
  int   n_frames = 0;
  bit   in_frame = 1'b0;
  int   k = 0;
  logic [9:0] bits = '0;
  bit   incons = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .baud_en (baud_en),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (baud_mode)
      0: baud_en = 1'b0;
      1: baud_en = 1'b1;
      2: begin baud_div = (baud_div + 1) % 4; baud_en = (baud_div == 0); end
      default: baud_en = ($urandom_range(0, 2) == 0);
    endcase
  end

  // Reference receiver: a frame is 10 bits of 16 baud pulses each, starting at the first low level.
  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 1'b0;
      k = 0;
      exp_q.delete();
    end else begin
      chk("tx_busy", 32'(tx_busy), 32'(in_frame || !tx));
      if (!in_frame && !tx) begin
        in_frame = 1'b1;
        k = 0;
        bits = '0;
        incons = 1'b0;
      end
      chk("tx_done", 32'(tx_done), 32'(in_frame && baud_en && (k == 159)));
      if (tx_done) n_done++;
      if (in_frame && baud_en) begin
        if (k % 16 == 0) bits[k/16] = tx;
        else if (bits[k/16] !== tx) incons = 1'b1;
        k++;
        if (k == 160) begin
          in_frame = 1'b0;
          n_frames++;
          chk("bit_stable", 32'(incons), 32'(0));
          chk("start_stop", 32'({bits[9], bits[0]}), 32'(2'b10));
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame: got unexpected byte %0h, nothing queued", bits[8:1]);
          end else begin
            chk("frame_data", 32'(bits[8:1]), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic drive_wr(input logic v, input logic [7:0] d, input bit accept);
    @(posedge clk); #1;
    wr_en = v;
    wr_data = d;
    if (v && accept) exp_q.push_back(d);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || tx_busy) && n < budget);
    chk("drain_timeout", 32'(exp_q.size() != 0 || tx_busy), 32'(0));
  endtask

  task automatic wait_bit(input int target, input int budget);
    int n = 0;
    while (!(in_frame && k >= target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_timeout", 32'(in_frame && k >= target), 32'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n, gap, nb;
    bit seen, stall_bad;
    logic [7:0] b;

    // Reset held with random inputs
    baud_mode = 3;
    for (int i = 0; i < 20; i++) begin
      drive_wr(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      @(negedge clk);
      chk("reset_outs", 32'({tx, tx_busy, tx_done, empty, full}), 32'(5'b10010));
    end
    drive_wr(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    baud_mode = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset", 32'({tx, tx_busy, tx_done, empty, full}), 32'(5'b10010));
    end

    // Single byte 0x55 with baud_en every clk; cycle c = the clk after edge c
    drive_wr(1'b1, 8'h55, 1'b1);
    drive_wr(1'b0, 8'h00, 1'b0);
    for (int c = 0; c <= 162; c++) begin
      @(negedge clk);
      case (c)
        0:   chk("c0", 32'({tx, tx_busy, empty}), 32'(3'b100));
        1:   chk("c1", 32'({tx, tx_busy, empty}), 32'(3'b011));
        16:  chk("c16_start", 32'(tx), 32'(0));
        17:  chk("c17_bit0", 32'(tx), 32'(1));
        33:  chk("c33_bit1", 32'(tx), 32'(0));
        144: chk("c144_bit7", 32'(tx), 32'(0));
        145: chk("c145_stop", 32'(tx), 32'(1));
        160: chk("c160_done", 32'({tx_done, tx_busy}), 32'(2'b11));
        161: chk("c161_idle", 32'({tx_done, tx_busy, tx}), 32'(3'b001));
        default: ;
      endcase
    end

    // Back-to-back frames with baud_en every 4 clks
    baud_mode = 2;
    d0 = n_done;
    for (int i = 0; i < 4; i++) drive_wr(1'b1, 8'(8'h31 + i), 1'b1);
    drive_wr(1'b0, 8'h00, 1'b0);
    gap = 0; seen = 1'b0; n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 4000) begin
      @(negedge clk);
      n++;
      if (tx_busy) seen = 1'b1;
      else if (seen && exp_q.size() != 0) gap++;
    end
    chk("b2b_timeout", 32'(exp_q.size() != 0 || tx_busy), 32'(0));
    chk("b2b_gap", 32'(gap), 32'(0));
    chk("b2b_done_count", 32'(n_done - d0), 32'(4));

    // Overflow with baud_en stopped: A0 pops at once, A1..A4 fill, A5 dropped
    baud_mode = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) drive_wr(1'b1, 8'(8'hA0 + i), 1'b1);
    drive_wr(1'b1, 8'hA5, 1'b0);
    @(negedge clk);
    chk("ovf_full_after_A4", 32'({full, empty}), 32'(2'b10));
    drive_wr(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("ovf_full_after_A5", 32'({full, empty}), 32'(2'b10));
    chk("ovf_frozen_start", 32'(tx), 32'(0));
    baud_mode = 1;
    drain(2000);

    // Random bursts with random baud_en; bursts of <=5 into an idle FIFO never overflow
    baud_mode = 3;
    for (int bi = 0; bi < 4; bi++) begin
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        drive_wr(1'b1, b, 1'b1);
        repeat ($urandom_range(0, 2)) drive_wr(1'b0, 8'h00, 1'b0);
      end
      drive_wr(1'b0, 8'h00, 1'b0);
      drain(20000);
    end

    // Reset during data bit 3 of 0xF0
    baud_mode = 1;
    drive_wr(1'b1, 8'hF0, 1'b1);
    drive_wr(1'b0, 8'h00, 1'b0);
    wait_bit(70, 300);
    chk("rst_mid_bit3", 32'(tx), 32'(0));
    d0 = n_done;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_async", 32'({tx, tx_busy, tx_done, empty, full}), 32'(5'b10010));
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", 32'({tx, tx_done}), 32'(2'b10));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_no_done", 32'(n_done - d0), 32'(0));
    chk("rst_idle", 32'({tx, tx_busy, empty}), 32'(3'b101));
    drive_wr(1'b1, 8'h0F, 1'b1);
    drive_wr(1'b0, 8'h00, 1'b0);
    drain(400);

    // Stall baud_en for 50 clks in the middle of the start bit
    drive_wr(1'b1, 8'h3D, 1'b1);
    drive_wr(1'b0, 8'h00, 1'b0);
    wait_bit(8, 100);
    baud_mode = 0;
    @(negedge clk);
    stall_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b0 || tx_busy !== 1'b1) stall_bad = 1'b1;
    end
    chk("stall_hold", 32'(stall_bad), 32'(0));
    baud_mode = 1;
    drain(400);

    chk("leftover", 32'(exp_q.size()), 32'(0));
    chk("frames_seen", 32'(n_frames > 0), 32'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
